// File: rtl/seq_mult.sv
// seq_mult: radix-2 shift-add sequential multiplier, WIDTH cycles per product.
// Define SEQ_MULT_SIGNED_EN to add the signed_mode port and the two's-complement path.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] q
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   mc;
  logic [WIDTH:0]     hi_ext, mc_ext, sum;
  logic               last, accept;
  assign last   = cnt == CW'(WIDTH - 1);
  assign accept = start && state != RUN;
  assign busy   = state == RUN;
  assign done   = state == DONE;
`ifdef SEQ_MULT_SIGNED_EN
  logic sm;
  // signed partial sums are sign-extended; the multiplier MSB step subtracts
  always_comb begin
    hi_ext = {sm & acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
    mc_ext = {sm & mc[WIDTH-1], mc};
    sum    = !acc[0] ? hi_ext : (sm && last) ? hi_ext - mc_ext : hi_ext + mc_ext;
  end
`else
  always_comb begin
    hi_ext = {1'b0, acc[2*WIDTH-1:WIDTH]};
    mc_ext = {1'b0, mc};
    sum    = acc[0] ? hi_ext + mc_ext : hi_ext;
  end
`endif
  // the carry/sign bit of the sum becomes the new accumulator MSB
  assign acc_nxt = {sum, acc[WIDTH-1:1]};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      mc    <= '0;
      q     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sm    <= 1'b0;
`endif
    end else if (accept) begin
      state <= RUN;
      cnt   <= '0;
      acc   <= {{WIDTH{1'b0}}, mplier};
      mc    <= mcand;
`ifdef SEQ_MULT_SIGNED_EN
      sm    <= signed_mode;
`endif
    end else if (state == RUN) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        state <= DONE;
        q     <= acc_nxt;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: random and directed checks of seq_mult at WIDTH 8 and 16 against a countdown/product model.
module tb_seq_mult;
`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SIG = 1'b1;
`else
  localparam bit SIG = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rn[2], st[2], sm[2];
  logic [31:0] a[2], b[2];
  logic        busy8, done8, busy16, done16;
  logic [15:0] q8;
  logic [31:0] q16;
  logic        bz[2], dn[2];
  logic [31:0] qv[2];
  int          rem[2];
  logic [31:0] pend[2], eq[2];
  logic        ed[2];
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(8)) d8 (
    .clk(clk), .reset_n(rn[0]), .start(st[0]), .mcand(a[0][7:0]), .mplier(b[0][7:0]),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode(sm[0]),
`endif
    .busy(busy8), .done(done8), .q(q8));

  seq_mult #(.WIDTH(16)) d16 (
    .clk(clk), .reset_n(rn[1]), .start(st[1]), .mcand(a[1][15:0]), .mplier(b[1][15:0]),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode(sm[1]),
`endif
    .busy(busy16), .done(done16), .q(q16));

  assign bz[0] = busy8;
  assign bz[1] = busy16;
  assign dn[0] = done8;
  assign dn[1] = done16;
  assign qv[0] = 32'(q8);
  assign qv[1] = q16;

  function automatic int wof(int i);
    return i == 0 ? 8 : 16;
  endfunction

  function automatic logic [31:0] ref_mul(logic [31:0] x, logic [31:0] y, bit s, int w);
    longint m, sx, sy;
    m  = (longint'(1) << w) - 1;
    sx = longint'(x) & m;
    sy = longint'(y) & m;
    if (s && ((sx >> (w - 1)) & 1) == 1) sx = sx - (m + 1);
    if (s && ((sy >> (w - 1)) & 1) == 1) sy = sy - (m + 1);
    return 32'((sx * sy) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s w%0d got=%h want=%h", nm, wof(i), act, exp);
    end
  endtask

  // model: an accept arms a WIDTH-cycle countdown; done and the product appear when it expires
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rn[i]) begin
        rem[i] <= 0;
        eq[i]  <= '0;
        ed[i]  <= 1'b0;
      end else begin
        ed[i] <= rem[i] == 1;
        if (rem[i] == 1) eq[i] <= pend[i];
        if (rem[i] != 0) rem[i] <= rem[i] - 1;
        else if (st[i]) begin
          rem[i]  <= wof(i);
          pend[i] <= ref_mul(a[i], b[i], sm[i] & SIG, wof(i));
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("busy", i, 32'(bz[i]), 32'(rn[i] && rem[i] != 0));
      chk("done", i, 32'(dn[i]), 32'(rn[i] && ed[i]));
      chk("q", i, qv[i], rn[i] ? eq[i] : 32'd0);
    end
  end

  task automatic op(int i, logic [31:0] x, logic [31:0] y, bit s);
    @(negedge clk);
    #1;
    a[i]  = x;
    b[i]  = y;
    sm[i] = s;
    st[i] = 1'b1;
    @(negedge clk);
    #1;
    st[i] = 1'b0;
  endtask

  task automatic wait_done(int i, logic [31:0] expq, string nm);
    int n;
    n = 0;
    while (!dn[i] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, i, 32'(n), 32'(wof(i)));
    chk(nm, i, qv[i], expq);
  endtask

  initial begin
    int cnt;
    rn = '{1'b0, 1'b0};
    st = '{1'b0, 1'b0};
    sm = '{1'b0, 1'b0};
    a  = '{32'd0, 32'd0};
    b  = '{32'd0, 32'd0};
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, 32'(bz[i]), 32'd0);
      chk("rst_done", i, 32'(dn[i]), 32'd0);
      chk("rst_q", i, qv[i], 32'd0);
    end
    // accept on the very first edge after reset release
    rn    = '{1'b1, 1'b1};
    a[0]  = 32'hA0;
    b[0]  = 32'hD4;
    st[0] = 1'b1;
    @(negedge clk);
    #1;
    st[0] = 1'b0;
    wait_done(0, 32'h8480, "A0xD4");
    op(0, 32'hFF, 32'hFF, 1'b0);
    wait_done(0, 32'hFE01, "FFxFF");
    op(0, 32'h00, 32'hD4, 1'b0);
    wait_done(0, 32'h0000, "00xD4");
    op(0, 32'h80, 32'h80, 1'b0);
    wait_done(0, 32'h4000, "80x80u");
`ifdef SEQ_MULT_SIGNED_EN
    op(0, 32'hA0, 32'hD4, 1'b1);
    wait_done(0, 32'h1080, "A0xD4s");
    op(0, 32'h80, 32'h80, 1'b1);
    wait_done(0, 32'h4000, "80x80s");
    op(0, 32'hFF, 32'hFF, 1'b1);
    wait_done(0, 32'h0001, "FFxFFs");
`endif
    // start held high, operands changing every cycle
    @(negedge clk);
    #1;
    st[0] = 1'b1;
    cnt   = 0;
    for (int j = 0; j < 270; j++) begin
      a[0]  = $urandom & 32'hFF;
      b[0]  = $urandom & 32'hFF;
      sm[0] = 1'($urandom) & SIG;
      @(negedge clk);
      if (dn[0]) cnt++;
      #1;
    end
    st[0] = 1'b0;
    chk("b2b_cnt", 0, 32'(cnt), 32'd30);
    // reset three cycles into a run
    op(0, 32'h37, 32'h5B, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    rn[0] = 1'b0;
    #1;
    chk("abort_busy", 0, 32'(bz[0]), 32'd0);
    chk("abort_q", 0, qv[0], 32'd0);
    chk("abort_done", 0, 32'(dn[0]), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    rn[0] = 1'b1;
    repeat (15) @(negedge clk);
    op(0, 32'h37, 32'h5B, 1'b0);
    wait_done(0, 32'h138D, "37x5B");
    // WIDTH=16 regression: 1000 back-to-back random products
    @(negedge clk);
    #1;
    st[1] = 1'b1;
    cnt   = 0;
    for (int j = 0; j < 17000; j++) begin
      a[1]  = $urandom & 32'hFFFF;
      b[1]  = $urandom & 32'hFFFF;
      sm[1] = 1'($urandom) & SIG;
      @(negedge clk);
      if (dn[1]) cnt++;
      #1;
    end
    st[1] = 1'b0;
    chk("w16_cnt", 1, 32'(cnt), 32'd1000);
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
